// File: rtl/pll_lock_rst_seq.sv
// Debounces the asynchronous PLL lock and sequences the two PLL-domain resets, then ready.
// Optional PLL reset-on-timeout logic is built only when PLL_LOCK_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module pll_lock_rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int GAP_CYCLES     = 16,
  parameter int LOSS_CNT_W     = 8,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int PLL_RST_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock_async,
  input  logic                  clr_sticky,
  output logic                  rst_out0,
  output logic                  rst_out1,
  output logic                  ready,
  output logic                  lock_lost_sticky,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [2:0]            seq_state,
  output logic                  pll_rst_req
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    REL0      = 3'd3,
    REL1      = 3'd4,
    RUN       = 3'd5
  } state_t;

  localparam int MAXC  = (STABLE_CYCLES > GAP_CYCLES) ? STABLE_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

  state_t                  state, nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    lock_s;
  logic                    loss;
  logic                    force_wait;
  logic                    rst0_nxt, rst1_nxt, ready_nxt, sticky_nxt;
  logic [LOSS_CNT_W-1:0]   loss_cnt_nxt;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign seq_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q           <= '0;
      state            <= IDLE;
      cnt              <= '0;
      rst_out0         <= 1'b1;
      rst_out1         <= 1'b1;
      ready            <= 1'b0;
      lock_lost_sticky <= 1'b0;
      loss_count       <= '0;
    end else begin
      sync_q           <= {sync_q[SYNC_STAGES-2:0], pll_lock_async};
      state            <= nxt;
      cnt              <= cnt_nxt;
      rst_out0         <= rst0_nxt;
      rst_out1         <= rst1_nxt;
      ready            <= ready_nxt;
      lock_lost_sticky <= sticky_nxt;
      loss_count       <= loss_cnt_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    loss    = 1'b0;
    case (state)
      IDLE: begin
        nxt     = WAIT_LOCK;
        cnt_nxt = '0;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          nxt     = STABLE;
          cnt_nxt = '0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          nxt     = WAIT_LOCK;
          cnt_nxt = '0;
        end else if (cnt == STABLE_LAST) begin
          nxt     = REL0;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REL0: begin
        if (!lock_s) begin
          loss = 1'b1;
        end else if (cnt == GAP_LAST) begin
          nxt     = REL1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REL1: begin
        if (!lock_s) begin
          loss = 1'b1;
        end else if (cnt == GAP_LAST) begin
          nxt     = RUN;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) loss = 1'b1;
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
    endcase

    if (loss) begin
      nxt     = WAIT_LOCK;
      cnt_nxt = '0;
    end
    // A timeout (or an in-flight PLL reset pulse) overrides whatever lock_s says.
    if (force_wait) begin
      nxt     = WAIT_LOCK;
      cnt_nxt = '0;
    end

    // Outputs are registered from the state being entered so they align with seq_state.
    rst0_nxt  = !((nxt == REL0) || (nxt == REL1) || (nxt == RUN));
    rst1_nxt  = !((nxt == REL1) || (nxt == RUN));
    ready_nxt = (nxt == RUN);

    sticky_nxt = lock_lost_sticky;
    if (clr_sticky) sticky_nxt = 1'b0;
    if (loss)       sticky_nxt = 1'b1;

    loss_cnt_nxt = loss_count;
    if (loss && (loss_count != {LOSS_CNT_W{1'b1}})) loss_cnt_nxt = loss_count + 1'b1;
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int PUL_W = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(PLL_RST_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic [PUL_W-1:0] pul_cnt;
  logic             req_q;
  logic             tmo_run;
  logic             tmo_fire;

  assign tmo_run     = (state == WAIT_LOCK) || (state == STABLE);
  assign tmo_fire    = !req_q && tmo_run && (tmo_cnt == TMO_LAST);
  assign force_wait  = req_q || tmo_fire;
  assign pll_rst_req = req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      pul_cnt <= '0;
      req_q   <= 1'b0;
    end else if (req_q) begin
      tmo_cnt <= '0;
      if (pul_cnt == PUL_LAST) begin
        req_q   <= 1'b0;
        pul_cnt <= '0;
      end else begin
        pul_cnt <= pul_cnt + 1'b1;
      end
    end else if (tmo_fire) begin
      req_q   <= 1'b1;
      pul_cnt <= '0;
      tmo_cnt <= '0;
    end else if (tmo_run && (nxt != REL0)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign force_wait  = 1'b0;
  assign pll_rst_req = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed bench for pll_lock_rst_seq with small parameters (STABLE=8, GAP=4, loss counter 2 bits).
`timescale 1ns/1ps
module tb_pll_lock_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock_async;
  logic       clr_sticky;
  logic       rst_out0, rst_out1, ready, lock_lost_sticky, pll_rst_req;
  logic [1:0] loss_count;
  logic [2:0] seq_state;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  pll_lock_rst_seq #(
    .SYNC_STAGES(2), .STABLE_CYCLES(8), .GAP_CYCLES(4), .LOSS_CNT_W(2),
    .TIMEOUT_CYCLES(20), .PLL_RST_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock_async(pll_lock_async), .clr_sticky(clr_sticky),
    .rst_out0(rst_out0), .rst_out1(rst_out1), .ready(ready),
    .lock_lost_sticky(lock_lost_sticky), .loss_count(loss_count),
    .seq_state(seq_state), .pll_rst_req(pll_rst_req)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pll_lock_async = 1'b0; clr_sticky = 1'b0;
    tick(3);
    chk("rst_state",  32'(seq_state), 0);
    chk("rst_out0_r", 32'(rst_out0), 1);
    chk("rst_out1_r", 32'(rst_out1), 1);
    chk("ready_r",    32'(ready), 0);
    chk("sticky_r",   32'(lock_lost_sticky), 0);
    chk("loss_r",     32'(loss_count), 0);
    chk("pllreq_r",   32'(pll_rst_req), 0);

    // Scenario 1: lock rises before edge 1
    rst = 1'b0; pll_lock_async = 1'b1;
    tick(1);  chk("s1_e1_wait", 32'(seq_state), 1);
    tick(9);  chk("s1_e10_r0", 32'(rst_out0), 1);
              chk("s1_e10_st", 32'(seq_state), 2);
    tick(1);  chk("s1_e11_r0", 32'(rst_out0), 0);
              chk("s1_e11_st", 32'(seq_state), 3);
              chk("s1_e11_r1", 32'(rst_out1), 1);
    tick(3);  chk("s1_e14_r1", 32'(rst_out1), 1);
    tick(1);  chk("s1_e15_r1", 32'(rst_out1), 0);
              chk("s1_e15_rdy", 32'(ready), 0);
    tick(3);  chk("s1_e18_rdy", 32'(ready), 0);
    tick(1);  chk("s1_e19_rdy", 32'(ready), 1);
              chk("s1_e19_st", 32'(seq_state), 5);
              chk("s1_loss", 32'(loss_count), 0);

    // Scenario 3: lose lock in RUN, then re-lock
    pll_lock_async = 1'b0;
    tick(2);  chk("s3_still_rdy", 32'(ready), 1);
    tick(1);  chk("s3_st", 32'(seq_state), 1);
              chk("s3_r0", 32'(rst_out0), 1);
              chk("s3_r1", 32'(rst_out1), 1);
              chk("s3_rdy", 32'(ready), 0);
              chk("s3_sticky", 32'(lock_lost_sticky), 1);
              chk("s3_loss", 32'(loss_count), 1);
    pll_lock_async = 1'b1;
    tick(10); chk("s3_re_r0_hi", 32'(rst_out0), 1);
    tick(1);  chk("s3_re_r0_lo", 32'(rst_out0), 0);
    tick(3);  chk("s3_re_r1_hi", 32'(rst_out1), 1);
    tick(1);  chk("s3_re_r1_lo", 32'(rst_out1), 0);
    tick(3);  chk("s3_re_rdy0", 32'(ready), 0);
    tick(1);  chk("s3_re_rdy1", 32'(ready), 1);

    // Scenario 4: losses 2..4, saturation and sticky clear priority
    pll_lock_async = 1'b0;
    tick(3);  chk("s4_loss2", 32'(loss_count), 2);
    clr_sticky = 1'b1; tick(1); clr_sticky = 1'b0;
    chk("s4_clr_a", 32'(lock_lost_sticky), 0);
    pll_lock_async = 1'b1;
    tick(11); chk("s4_rel0_a", 32'(seq_state), 3);
    pll_lock_async = 1'b0;
    tick(3);  chk("s4_loss3", 32'(loss_count), 3);
              chk("s4_sticky3", 32'(lock_lost_sticky), 1);
    pll_lock_async = 1'b1;
    tick(11); chk("s4_rel0_b", 32'(seq_state), 3);
    pll_lock_async = 1'b0;
    tick(2);  clr_sticky = 1'b1;
    tick(1);  clr_sticky = 1'b0;
              chk("s4_loss_sat", 32'(loss_count), 3);
              chk("s4_set_wins", 32'(lock_lost_sticky), 1);
              chk("s4_st_wait", 32'(seq_state), 1);
    clr_sticky = 1'b1; tick(1); clr_sticky = 1'b0;
    chk("s4_clr_b", 32'(lock_lost_sticky), 0);

    // Scenario 5: rst while in REL1
    pll_lock_async = 1'b1;
    tick(11); chk("s5_rel0", 32'(seq_state), 3);
    tick(4);  chk("s5_rel1", 32'(seq_state), 4);
              chk("s5_r1_lo", 32'(rst_out1), 0);
    rst = 1'b1;
    tick(1);  chk("s5_idle", 32'(seq_state), 0);
              chk("s5_r0", 32'(rst_out0), 1);
              chk("s5_r1", 32'(rst_out1), 1);
              chk("s5_loss", 32'(loss_count), 0);

    // Scenario 2: one-cycle lock_s glitch at STABLE count 5
    rst = 1'b0;
    tick(6);  pll_lock_async = 1'b0;
    tick(1);  pll_lock_async = 1'b1;
    tick(1);  chk("s2_stable", 32'(seq_state), 2);
    tick(1);  chk("s2_back_wait", 32'(seq_state), 1);
              chk("s2_no_loss", 32'(loss_count), 0);
              chk("s2_no_sticky", 32'(lock_lost_sticky), 0);
    tick(8);  chk("s2_r0_hi", 32'(rst_out0), 1);
              chk("s2_st_e17", 32'(seq_state), 2);
    tick(1);  chk("s2_r0_lo", 32'(rst_out0), 0);

    // Scenario 6: lock held low
    pll_lock_async = 1'b0;
    tick(3);  chk("s6_wait", 32'(seq_state), 1);
`ifdef PLL_LOCK_TIMEOUT_EN
    tick(19); chk("s6_req_pre", 32'(pll_rst_req), 0);
    tick(1);  chk("s6_req_on", 32'(pll_rst_req), 1);
    tick(7);  chk("s6_req_last", 32'(pll_rst_req), 1);
    tick(1);  chk("s6_req_off", 32'(pll_rst_req), 0);
    tick(19); chk("s6_req_pre2", 32'(pll_rst_req), 0);
    tick(1);  chk("s6_req_on2", 32'(pll_rst_req), 1);
`else
    tick(20); chk("s6_req_a", 32'(pll_rst_req), 0);
    tick(10); chk("s6_req_b", 32'(pll_rst_req), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
